// File: rtl/fifo_pkt_reader_pkg.sv
// Shared constants and types for the router output-port packet reader.
package router_pkg;
  localparam int DW          = 8;
  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int ADDR_MSB    = 1;
  localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
  localparam int TIMEOUT_DEF = 30;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    BODY     = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } buf_entry_t;

  // Bytes still to fetch after the header: payload plus the trailing parity byte.
  function automatic logic [LEN_W:0] hdr_span(input logic [LEN_W-1:0] len);
    return {1'b0, len} + {{LEN_W{1'b0}}, 1'b1};
  endfunction
endpackage

// File: rtl/fifo_pkt_reader_if.sv
// Handshake bundle between the reader, its output FIFO and the destination port.
interface fifo_pkt_reader_if;
  import router_pkg::*;

  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_re;
  logic          fifo_sft;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic          out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_re, fifo_sft, out_data, out_valid, out_first, out_last
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_re, fifo_sft, out_data, out_valid, out_first, out_last
  );
endinterface

// File: rtl/fifo_pkt_reader_skid_buf.sv
// Two-entry tagged output buffer; head is zeroed while empty so idle outputs read 0.
module pkt_skid_buf
  import router_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  buf_entry_t i_din,
  input  logic       i_pop,
  output buf_entry_t o_head,
  output logic       o_valid,
  output logic [1:0] o_count
);
  buf_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side master of a router output FIFO: reframes bytes into packets, checks parity,
// and soft-resets the FIFO when the destination stalls too long.
//   state    | meaning
//   IDLE     | free to issue the next header read
//   HDR_WAIT | header read in flight, length not yet known
//   BODY     | issuing payload and parity reads
module fifo_pkt_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  fifo_pkt_reader_if.master        bus,
  output logic                     o_parity_err,
  output logic                     o_busy
);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};

  rd_state_t      r_state;
  rd_state_t      w_next_state;
  logic           r_inflight;
  logic           r_infl_hdr;
  logic           r_infl_last;
  logic [LEN_W:0] r_remaining;
  logic [DW-1:0]  r_acc;
  logic [SW-1:0]  r_stall;
  logic           r_parity_err;

  buf_entry_t     w_head;
  buf_entry_t     w_din;
  logic           w_head_valid;
  logic [1:0]     w_occ;
  logic [2:0]     w_level;
  logic           w_pop;
  logic           w_stall;
  logic           w_flush;
  logic           w_push;
  logic           w_credit;
  logic           w_can_read;
  logic           w_issue;
  logic           w_issue_hdr;
  logic           w_issue_last;

  assign w_pop      = w_head_valid & bus.out_ready;
  assign w_stall    = w_head_valid & ~bus.out_ready;
  assign w_flush    = ~i_rst & w_stall & (r_stall == SW'(TIMEOUT - 1));
  assign w_push     = r_inflight & ~w_flush;
  // Credit counts buffered plus in-flight bytes after this cycle's pop.
  assign w_level    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit   = (w_level < 3'd2);
  assign w_can_read = ~i_rst & ~w_flush & ~bus.fifo_empty & w_credit;

  assign w_din = '{data: bus.fifo_dout, first: r_infl_hdr, last: r_infl_last};

  pkt_skid_buf u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_occ)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush) r_state <= IDLE;
    else                  r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_can_read) w_next_state = HDR_WAIT;
      HDR_WAIT: if (r_inflight) w_next_state = BODY;
      BODY:     if (w_can_read && (r_remaining == REM_ONE)) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_issue      = 1'b0;
    w_issue_hdr  = 1'b0;
    w_issue_last = 1'b0;
    case (r_state)
      IDLE: begin
        w_issue     = w_can_read;
        w_issue_hdr = w_can_read;
      end
      BODY: begin
        w_issue      = w_can_read & (r_remaining != '0);
        w_issue_last = w_can_read & (r_remaining == REM_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush) begin
      r_inflight  <= 1'b0;
      r_infl_hdr  <= 1'b0;
      r_infl_last <= 1'b0;
      r_remaining <= '0;
      r_acc       <= '0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_hdr  <= w_issue_hdr;
      r_infl_last <= w_issue_last;
      if (r_inflight && r_infl_hdr) begin
        r_remaining <= hdr_span(bus.fifo_dout[LEN_MSB:LEN_LSB]);
        r_acc       <= bus.fifo_dout;
      end else begin
        if (w_issue && !w_issue_hdr) r_remaining <= r_remaining - REM_ONE;
        if (r_inflight && !r_infl_last) r_acc <= r_acc ^ bus.fifo_dout;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_parity_err <= 1'b0;
    else       r_parity_err <= w_push & r_infl_last & (bus.fifo_dout != r_acc);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush || !w_stall) r_stall <= '0;
    else                              r_stall <= r_stall + SW'(1);
  end

  assign bus.fifo_re   = w_issue;
  assign bus.fifo_sft  = w_flush;
  assign bus.out_data  = w_head.data;
  assign bus.out_valid = w_head_valid;
  assign bus.out_first = w_head.first;
  assign bus.out_last  = w_head.last;
  assign o_parity_err  = r_parity_err;
  assign o_busy        = (r_state != IDLE) | w_head_valid | r_inflight;
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a FIFO model feeds packets, a negedge monitor records the stream.
`timescale 1ns/1ps
module tb_fifo_pkt_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic perr;
  logic busy;

  always #5 clk = ~clk;

  fifo_pkt_reader_if bus();

  fifo_pkt_reader #(.TIMEOUT(30)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus),
    .o_parity_err (perr),
    .o_busy       (busy)
  );

  // FIFO model: one-cycle read latency, cleared by soft reset or router reset
  logic [7:0] fmem [0:1023];
  logic [9:0] wr_idx = '0;
  logic [9:0] rd_idx = '0;

  assign bus.fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (rst || bus.fifo_sft) rd_idx <= wr_idx;
    else if (bus.fifo_re) begin
      bus.fifo_dout <= fmem[rd_idx];
      rd_idx        <= rd_idx + 10'd1;
    end
  end

  // Monitor
  logic       acc_now;
  int         cyc = 0;
  logic [9:0] rx_q [$];
  int         rx_cyc [$];
  int         re_cyc [$];
  int         perr_cnt = 0;
  int         perr_cyc = -1;
  int         sft_cnt = 0;
  int         outst = 0;
  int         max_out = 0;
  int         credit_viol = 0;
  int         hold_viol = 0;
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic       p_sft = 1'b0;
  logic       p_rst = 1'b1;
  logic [7:0] p_data = '0;

  assign acc_now = bus.out_valid & bus.out_ready;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_re) begin
      re_cyc.push_back(cyc);
      if ((outst - int'(acc_now)) >= 2) credit_viol <= credit_viol + 1;
    end
    if (acc_now) begin
      rx_q.push_back({bus.out_first, bus.out_last, bus.out_data});
      rx_cyc.push_back(cyc);
    end
    if (perr) begin
      perr_cnt <= perr_cnt + 1;
      perr_cyc <= cyc;
    end
    if (bus.fifo_sft) sft_cnt <= sft_cnt + 1;
    if (rst || bus.fifo_sft) outst <= 0;
    else outst <= outst + int'(bus.fifo_re) - int'(acc_now);
    if (outst > max_out) max_out <= outst;
    if (p_valid && !p_ready && !p_sft && !p_rst &&
        (!bus.out_valid || (bus.out_data != p_data)))
      hold_viol <= hold_viol + 1;
    p_valid <= bus.out_valid;
    p_ready <= bus.out_ready;
    p_sft   <= bus.fifo_sft;
    p_rst   <= rst;
    p_data  <= bus.out_data;
  end

  int         n_tests = 0;
  int         n_fail = 0;
  logic [9:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rxc(input int i);
    return (i < rx_cyc.size()) ? rx_cyc[i] : -1000;
  endfunction

  function automatic int rec(input int i);
    return (i < re_cyc.size()) ? re_cyc[i] : -1000;
  endfunction

  task automatic put_exp(input logic [7:0] b, input logic first, input logic last);
    fmem[wr_idx] = b;
    wr_idx = wr_idx + 10'd1;
    exp_q.push_back({first, last, b});
  endtask

  task automatic load_pkt(input logic [5:0] len, input logic [1:0] addr,
                          input logic [7:0] seed, input bit bad);
    logic [7:0] hdr;
    logic [7:0] b;
    logic [7:0] par;
    hdr = {len, addr};
    par = hdr;
    put_exp(hdr, 1'b1, 1'b0);
    for (int i = 0; i < int'(len); i++) begin
      b = seed + 8'(i * 7);
      put_exp(b, 1'b0, 1'b0);
      par = par ^ b;
    end
    put_exp(bad ? ~par : par, 1'b0, 1'b1);
  endtask

  task automatic drain(input string tag, input int rx_base, input int budget, input bit toggle);
    int n;
    n = 0;
    while (((rx_q.size() - rx_base) < exp_q.size()) && (n < budget)) begin
      @(posedge clk);
      #1;
      if (toggle) bus.out_ready = ~bus.out_ready;
      n++;
    end
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk({tag, " count"}, rx_q.size() - rx_base, exp_q.size());
    for (int i = 0; (i < exp_q.size()) && ((rx_base + i) < rx_q.size()); i++)
      chk($sformatf("%s byte%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rxb, reb, pe0, cv0, sc0, stalls, n;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst fifo_re", bus.fifo_re, 0);
    chk("rst busy", busy, 0);
    chk("rst other outs", {bus.out_first, bus.out_last, bus.out_data, bus.fifo_sft, perr}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Basic packet, parity 0D^11^22^33 = 0D
    rxb = rx_q.size(); reb = re_cyc.size(); pe0 = perr_cnt;
    exp_q.delete();
    put_exp(8'h0D, 1'b1, 1'b0);
    put_exp(8'h11, 1'b0, 1'b0);
    put_exp(8'h22, 1'b0, 1'b0);
    put_exp(8'h33, 1'b0, 1'b0);
    put_exp(8'h0D, 1'b0, 1'b1);
    drain("basic", rxb, 60, 1'b0);
    chk("basic perr", perr_cnt - pe0, 0);
    chk("basic hdr latency", rxc(rxb) - rec(reb), 2);
    chk("basic bubble", rxc(rxb + 1) - rxc(rxb), 2);
    chk("basic body", rxc(rxb + 4) - rxc(rxb + 1), 3);

    // Parity error
    rxb = rx_q.size(); reb = re_cyc.size(); pe0 = perr_cnt;
    exp_q.delete();
    put_exp(8'h0D, 1'b1, 1'b0);
    put_exp(8'h11, 1'b0, 1'b0);
    put_exp(8'h22, 1'b0, 1'b0);
    put_exp(8'h33, 1'b0, 1'b0);
    put_exp(8'hFF, 1'b0, 1'b1);
    drain("perr", rxb, 60, 1'b0);
    chk("perr pulses", perr_cnt - pe0, 1);
    chk("perr timing", perr_cyc - rec(reb + 4), 2);
    chk("perr with parity byte", perr_cyc - rxc(rxb + 4), 0);

    // Zero-length packet back-to-back with a len=14 packet
    rxb = rx_q.size(); pe0 = perr_cnt; cv0 = credit_viol;
    exp_q.delete();
    load_pkt(6'd0, 2'd2, 8'h00, 1'b0);
    load_pkt(6'd14, 2'd1, 8'h40, 1'b0);
    drain("b2b", rxb, 100, 1'b0);
    chk("b2b perr", perr_cnt - pe0, 0);
    chk("b2b credit", credit_viol - cv0, 0);
    chk("b2b max outstanding ok", (max_out <= 2), 1);

    // Max packet under alternating backpressure
    rxb = rx_q.size(); pe0 = perr_cnt; cv0 = credit_viol;
    exp_q.delete();
    load_pkt(6'd63, 2'd0, 8'h80, 1'b0);
    drain("bp", rxb, 400, 1'b1);
    chk("bp perr", perr_cnt - pe0, 0);
    chk("bp credit", credit_viol - cv0, 0);
    chk("bp hold", hold_viol, 0);

    // Destination timeout
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    rxb = rx_q.size(); sc0 = sft_cnt;
    exp_q.delete();
    load_pkt(6'd3, 2'd3, 8'h50, 1'b0);
    stalls = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.out_valid && !bus.out_ready) stalls++;
    end while (!bus.fifo_sft && (n < 200));
    chk("tmo sft seen", bus.fifo_sft, 1);
    chk("tmo stall cycles", stalls, 30);
    @(negedge clk);
    chk("tmo valid after", bus.out_valid, 0);
    chk("tmo busy after", busy, 0);
    chk("tmo sft one cycle", bus.fifo_sft, 0);
    chk("tmo nothing delivered", rx_q.size() - rxb, 0);
    chk("tmo sft pulses", sft_cnt - sc0, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    rxb = rx_q.size();
    exp_q.delete();
    load_pkt(6'd5, 2'd1, 8'h60, 1'b0);
    drain("post tmo", rxb, 80, 1'b0);

    // Reset during BODY
    reb = re_cyc.size();
    exp_q.delete();
    load_pkt(6'd63, 2'd2, 8'hA0, 1'b0);
    n = 0;
    while (((re_cyc.size() - reb) < 12) && (n < 200)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rstmid reads", ((re_cyc.size() - reb) >= 12), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid fifo_re", bus.fifo_re, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmid outs", {bus.out_valid, bus.out_first, bus.out_last, bus.out_data,
                        bus.fifo_sft, bus.fifo_re, perr, busy}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rxb = rx_q.size(); pe0 = perr_cnt;
    exp_q.delete();
    load_pkt(6'd2, 2'd0, 8'h70, 1'b1);
    drain("post rst", rxb, 60, 1'b0);
    chk("post rst perr", perr_cnt - pe0, 1);
    chk("final hold", hold_viol, 0);
    chk("final credit", credit_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
